muldiv: RTL

- Iterative multiply/divide unit implementing the RV M-extension operations. Sits beside the single-cycle ALU in the execute stage.
- Takes the same rs1/rs2/s_32 operand form as the ALU and returns rd through a valid/ready handshake.
- The pipeline stalls on busy until the result is consumed.

---
 rtl/muldiv.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/muldiv.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide, N = 32 (W ops) or XLEN.
// Result after N+2 cycles, or 1 cycle for divide-by-zero/overflow; result held until out_ready, kill aborts.
module muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic            s_32,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rd,
   output logic            busy
);
   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state;
   logic [2:0]        op;
   logic              w;
   logic              neg_lo;    // negate product, or quotient
   logic              neg_hi;    // negate remainder
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     last;
   logic [2*XLEN-1:0] mc;        // shifting multiplicand, or divisor in the low half
   logic [2*XLEN-1:0] acc;       // product, or remainder in acc[XLEN:0]
   logic [XLEN-1:0]   sh;        // multiplier, or dividend shifting into quotient

   function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sg);
      logic [XLEN-1:0] r;
      r = v;
      for (int i = 32; i < XLEN; i++) r[i] = sg & v[31];
      return r;
   endfunction

   logic            is_div, w_in, a_sgn, b_sgn, sa, sb, dz, ovf;
   logic [XLEN-1:0] e1, e2, m1, m2, minv, spec_res;

   always_comb begin
      is_div = funct3[2];
      // MULH* has no W form, so s_32 only narrows MUL and the divides
      w_in   = (XLEN == 64) && s_32 && (is_div || funct3[1:0] == 2'd0);
      a_sgn  = is_div ? ~funct3[0] : (funct3[1:0] == 2'd1 || funct3[1:0] == 2'd2);
      b_sgn  = is_div ? ~funct3[0] : (funct3[1:0] == 2'd1);
      e1     = w_in ? ext32(rs1, a_sgn) : rs1;
      e2     = w_in ? ext32(rs2, b_sgn) : rs2;
      sa     = a_sgn & e1[XLEN-1];
      sb     = b_sgn & e2[XLEN-1];
      m1     = sa ? -e1 : e1;
      m2     = sb ? -e2 : e2;
      minv   = '0;
      minv[XLEN-1] = 1'b1;
      if (w_in) minv = ext32(XLEN'(32'h8000_0000), 1'b1);
      dz     = (e2 == '0);
      ovf    = is_div && a_sgn && (e1 == minv) && (&e2);
      if (dz) spec_res = funct3[1] ? (w_in ? ext32(rs1, 1'b1) : rs1) : '1;
      else    spec_res = funct3[1] ? '0 : minv;
   end

   logic [XLEN:0]   rem_sh;
   logic [XLEN+1:0] diff;
   always_comb begin
      rem_sh = {acc[XLEN-1:0], sh[XLEN-1]};
      diff   = {1'b0, rem_sh} - {2'b00, mc[XLEN-1:0]};
   end

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, res;
   always_comb begin
      prod = neg_lo ? -acc : acc;
      quo  = neg_lo ? -sh : sh;
      rem  = neg_hi ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      case (op)
         3'd0:             res = prod[XLEN-1:0];
         3'd1, 3'd2, 3'd3: res = prod[2*XLEN-1:XLEN];
         3'd4, 3'd5:       res = quo;
         default:          res = rem;
      endcase
      if (w) res = ext32(res, 1'b1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         rd        <= '0;
         op        <= '0;
         w         <= 1'b0;
         neg_lo    <= 1'b0;
         neg_hi    <= 1'b0;
         cnt       <= '0;
         last      <= '0;
         mc        <= '0;
         acc       <= '0;
         sh        <= '0;
      end else if (kill && state != IDLE) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready && !kill) begin
                  op       <= funct3;
                  w        <= w_in;
                  cnt      <= '0;
                  last     <= w_in ? CW'(31) : CW'(XLEN - 1);
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  acc      <= '0;
                  neg_lo   <= sa ^ sb;
                  neg_hi   <= sa;
                  mc       <= {{XLEN{1'b0}}, (is_div ? m2 : m1)};
                  // W divides left-align the dividend so the top quotient bit comes out first
                  sh       <= is_div ? (m1 << (w_in ? XLEN - 32 : 0)) : m2;
                  if (is_div && (dz || ovf)) begin
                     rd    <= spec_res;
                     state <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               cnt <= cnt + 1'b1;
               if (cnt == last) state <= FIX;
               if (op[2]) begin
                  if (!diff[XLEN+1]) begin
                     acc <= {{(XLEN-1){1'b0}}, diff[XLEN:0]};
                     sh  <= {sh[XLEN-2:0], 1'b1};
                  end else begin
                     acc <= {{(XLEN-1){1'b0}}, rem_sh};
                     sh  <= {sh[XLEN-2:0], 1'b0};
                  end
               end else begin
                  if (sh[0]) acc <= acc + mc;
                  mc <= mc << 1;
                  sh <= sh >> 1;
               end
            end
            FIX: begin
               rd    <= res;
               state <= DONE;
            end
            DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
